// File: rtl/eth_pkt_rr_arbiter_pkg.sv
// rtl/eth_pkt_rr_arbiter_pkg.sv - shared types, widths and helpers for the packet arbiter
//
// Purpose: FSM state type, stream field widths, default port count and the
//          request-rotation helper used by the round-robin priority select.
// Ports:   none (package).

package eth_arb_pkg;

    typedef enum logic {IDLE, XFER} t_arb_state;

    localparam int DEFAULT_NUM_PORTS = 8;
    localparam int MAX_PORTS         = 16;

    localparam int ETH_DATA_W  = 64;
    localparam int ETH_MOD_W   = 3;
    localparam int ETH_FLAGS_W = 4;
    localparam int ETH_TS_W    = 32;

    // Rotate req right by ptr within the low n bits, so bit 0 of the result is
    // the port at rr_ptr. Bits at and above n are returned as zero.
    function automatic logic [MAX_PORTS-1:0] rotate_req(
        input logic [MAX_PORTS-1:0] req,
        input logic [3:0]           ptr,
        input int                   n
    );
        logic [MAX_PORTS-1:0] r;
        int                   j;
        r = '0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (k < n) begin
                j = k + int'(ptr);
                if (j >= n) j = j - n;
                r[k] = req[4'(j)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_pkt_rr_arbiter_if.sv
// rtl/eth_pkt_rr_arbiter_if.sv - packet stream interface with tx/rx modports
//
// Purpose: one beat-level packet stream (data, sop, eop, mod, flags,
//          timestamp, valid/ready handshake).
// Modports: tx drives the beat and valid and samples ready;
//           rx samples the beat and valid and drives ready.

interface t_ETH_STREAM;
    import eth_arb_pkg::*;

    logic [ETH_DATA_W-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [ETH_MOD_W-1:0]   mod;
    logic [ETH_FLAGS_W-1:0] flags;
    logic [ETH_TS_W-1:0]    timestamp;
    logic                   valid;
    logic                   ready;

    modport tx (output data, sop, eop, mod, flags, timestamp, valid, input  ready);
    modport rx (input  data, sop, eop, mod, flags, timestamp, valid, output ready);

endinterface

// File: rtl/eth_pkt_rr_arbiter_sel.sv
// rtl/eth_pkt_rr_arbiter_sel.sv - combinational round-robin priority select
//
// Purpose: pick the first set request bit at or after i_rr_ptr, scanning
//          upward and wrapping modulo NUM_PORTS.
// Ports:   i_req     request vector
//          i_rr_ptr  index with highest priority this round
//          o_grant   one-hot winner (zero when no request)
//          o_index   binary index of the winner

module rr_priority_select
    import eth_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0]         i_req,
    input  logic [$clog2(NUM_PORTS)-1:0] i_rr_ptr,
    output logic [NUM_PORTS-1:0]         o_grant,
    output logic [$clog2(NUM_PORTS)-1:0] o_index
);

    localparam int PW = $clog2(NUM_PORTS);

    logic [MAX_PORTS-1:0] w_rot;
    logic                 w_found;
    int                   w_off;
    int                   w_sum;

    always_comb begin
        w_rot   = rotate_req(MAX_PORTS'(i_req), 4'(i_rr_ptr), NUM_PORTS);
        w_found = 1'b0;
        w_off   = 0;
        // Lowest set bit of the rotated vector is the nearest requester at or
        // after the pointer; bits beyond NUM_PORTS are always zero.
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
        w_sum = w_off + int'(i_rr_ptr);
        if (w_sum >= NUM_PORTS) w_sum = w_sum - NUM_PORTS;
        o_index = PW'(w_sum);
        o_grant = w_found ? (NUM_PORTS'(1) << w_sum) : '0;
    end

endmodule

// File: rtl/eth_pkt_rr_arbiter.sv
// rtl/eth_pkt_rr_arbiter.sv - packet-granular round-robin merge of NUM_PORTS streams
//
// Purpose: grant one port from sop to eop, forward its beats unchanged onto a
//          single output stream, then rotate priority past the served port.
// Ports:   i_clk, i_reset_n   clock, asynchronous active-low reset
//          if_eth_in[]        per-port input streams (rx)
//          i_pkt_avail        port holds at least one complete packet
//          i_port_enable      port may be granted (sampled at arbitration only)
//          if_eth_out         merged output stream (tx)
//          o_grant            one-hot current grant, zero when idle
//          o_busy             packet transfer in progress
//          o_pkt_count        eop beats forwarded, wrapping
//          o_proto_err        sticky: sop seen mid-packet on granted port

module eth_pkt_rr_arbiter
    import eth_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    t_ETH_STREAM.rx              if_eth_in [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] i_pkt_avail,
    input  logic [NUM_PORTS-1:0] i_port_enable,
    t_ETH_STREAM.tx              if_eth_out,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic                 o_busy,
    output logic [CNT_WIDTH-1:0] o_pkt_count,
    output logic                 o_proto_err
);

    localparam int PW = $clog2(NUM_PORTS);

    t_arb_state           r_state;
    logic [NUM_PORTS-1:0] r_grant;
    logic [PW-1:0]        r_idx;
    logic [PW-1:0]        r_rr_ptr;
    logic                 r_busy;
    logic                 r_first;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_proto_err;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_sel_grant;
    logic [PW-1:0]        w_sel_idx;
    logic                 w_acc;
    logic                 w_release;

    logic [ETH_DATA_W-1:0]  w_data  [NUM_PORTS];
    logic                   w_sop   [NUM_PORTS];
    logic                   w_eop   [NUM_PORTS];
    logic [ETH_MOD_W-1:0]   w_mod   [NUM_PORTS];
    logic [ETH_FLAGS_W-1:0] w_flags [NUM_PORTS];
    logic [ETH_TS_W-1:0]    w_ts    [NUM_PORTS];
    logic                   w_valid [NUM_PORTS];

    assign w_req = i_pkt_avail & i_port_enable;

    rr_priority_select #(.NUM_PORTS(NUM_PORTS)) u_sel (
        .i_req    (w_req),
        .i_rr_ptr (r_rr_ptr),
        .o_grant  (w_sel_grant),
        .o_index  (w_sel_idx)
    );

    // Interface arrays only take constant indices, so each port's fields are
    // flattened into plain arrays that the registered index can select from.
    // Ready is gated by the grant alone, never by valid, to stay loop-free
    // against FIFOs whose valid depends on their ready.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign w_data[gi]          = if_eth_in[gi].data;
        assign w_sop[gi]           = if_eth_in[gi].sop;
        assign w_eop[gi]           = if_eth_in[gi].eop;
        assign w_mod[gi]           = if_eth_in[gi].mod;
        assign w_flags[gi]         = if_eth_in[gi].flags;
        assign w_ts[gi]            = if_eth_in[gi].timestamp;
        assign w_valid[gi]         = if_eth_in[gi].valid;
        assign if_eth_in[gi].ready = r_grant[gi] & if_eth_out.ready;
    end

    assign if_eth_out.data      = w_data[r_idx];
    assign if_eth_out.sop       = w_sop[r_idx];
    assign if_eth_out.eop       = w_eop[r_idx];
    assign if_eth_out.mod       = w_mod[r_idx];
    assign if_eth_out.flags     = w_flags[r_idx];
    assign if_eth_out.timestamp = w_ts[r_idx];
    assign if_eth_out.valid     = r_busy & w_valid[r_idx];

    assign w_acc     = if_eth_out.valid & if_eth_out.ready;
    assign w_release = w_acc & if_eth_out.eop;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_rr_ptr    <= '0;
            r_busy      <= 1'b0;
            r_first     <= 1'b0;
            r_cnt       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_sel_grant;
                        r_idx   <= w_sel_idx;
                        r_busy  <= 1'b1;
                        r_first <= 1'b1;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_acc) begin
                        r_first <= 1'b0;
                        // A second sop inside the grant is flagged but the beat
                        // still flows and the grant is held to eop.
                        if (if_eth_out.sop && !r_first) r_proto_err <= 1'b1;
                    end
                    if (w_release) begin
                        r_rr_ptr <= (r_idx == PW'(NUM_PORTS - 1)) ? '0 : r_idx + PW'(1);
                        r_cnt    <= r_cnt + CNT_WIDTH'(1);
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = r_busy;
    assign o_pkt_count = r_cnt;
    assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_eth_pkt_rr_arbiter.sv
// tb/tb_eth_pkt_rr_arbiter.sv - self-checking bench for the packet round-robin arbiter

module tb_eth_pkt_rr_arbiter;
    import eth_arb_pkg::*;

    localparam int NP = 8;
    localparam int CW = 32;

    typedef struct packed {
        logic [ETH_DATA_W-1:0]  data;
        logic                   sop;
        logic                   eop;
        logic [ETH_MOD_W-1:0]   mod;
        logic [ETH_FLAGS_W-1:0] flags;
        logic [ETH_TS_W-1:0]    ts;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    beat_t          src_q [NP][$];
    beat_t          tb_beat [NP];
    logic [NP-1:0]  tb_valid  = '0;
    logic [NP-1:0]  tb_avail  = '0;
    logic [NP-1:0]  tb_enable = '0;
    logic [NP-1:0]  tb_ready;
    logic           out_ready = 1'b0;

    logic [NP-1:0]  o_grant;
    logic           o_busy;
    logic [CW-1:0]  o_pkt_count;
    logic           o_proto_err;

    t_ETH_STREAM in_if [NP] ();
    t_ETH_STREAM out_if ();

    for (genvar g = 0; g < NP; g++) begin : g_src
        assign in_if[g].data      = tb_beat[g].data;
        assign in_if[g].sop       = tb_beat[g].sop;
        assign in_if[g].eop       = tb_beat[g].eop;
        assign in_if[g].mod       = tb_beat[g].mod;
        assign in_if[g].flags     = tb_beat[g].flags;
        assign in_if[g].timestamp = tb_beat[g].ts;
        assign in_if[g].valid     = tb_valid[g];
        assign tb_ready[g]        = in_if[g].ready;
    end
    assign out_if.ready = out_ready;

    eth_pkt_rr_arbiter #(.NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .if_eth_in     (in_if),
        .i_pkt_avail   (tb_avail),
        .i_port_enable (tb_enable),
        .if_eth_out    (out_if),
        .o_grant       (o_grant),
        .o_busy        (o_busy),
        .o_pkt_count   (o_pkt_count),
        .o_proto_err   (o_proto_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: which port owns the output, who is next in line,
    // how many packets have left, and whether a stray sop has been seen.
    bit      m_busy = 0;
    int      m_port = 0;
    int      m_ptr  = 0;
    int      m_cnt  = 0;
    bit      m_first = 0;
    bit      m_err  = 0;

    int      rdy_pct = 100;
    int      vld_pct = 100;
    bit      en_rand = 0;

    function automatic logic [NP-1:0] onehot(input int p);
        return NP'(1) << p;
    endfunction

    task automatic add_pkt(input int port, input int len, input bit bad);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = {$urandom, $urandom};
            b.sop   = (i == 0) || (bad && i == 2);
            b.eop   = (i == len - 1);
            b.mod   = ETH_MOD_W'($urandom);
            b.flags = ETH_FLAGS_W'($urandom);
            b.ts    = $urandom;
            src_q[port].push_back(b);
        end
    endtask

    task automatic step();
        beat_t ob;
        beat_t b;
        logic [NP-1:0] req;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            tb_avail[p] = (src_q[p].size() > 0);
            tb_valid[p] = tb_avail[p] && ($urandom_range(99) < vld_pct);
            tb_beat[p]  = tb_avail[p] ? src_q[p][0] : '0;
        end
        tb_enable = en_rand ? NP'($urandom) : '1;
        out_ready = ($urandom_range(99) < rdy_pct);
        #1;
        check_eq("grant",     o_grant, m_busy ? onehot(m_port) : '0);
        check_eq("busy",      o_busy, m_busy);
        check_eq("pkt_count", o_pkt_count, CW'(m_cnt));
        check_eq("proto_err", o_proto_err, m_err);
        check_eq("in_ready",  tb_ready, (m_busy && out_ready) ? onehot(m_port) : '0);
        check_eq("out_valid", out_if.valid, m_busy && tb_valid[m_port]);
        if (m_busy && tb_valid[m_port]) begin
            ob = {out_if.data, out_if.sop, out_if.eop, out_if.mod, out_if.flags, out_if.timestamp};
            check_eq("out_beat", ob, src_q[m_port][0]);
        end
        if (m_busy) begin
            if (tb_valid[m_port] && out_ready) begin
                b = src_q[m_port].pop_front();
                if (b.sop && !m_first) m_err = 1;
                m_first = 0;
                if (b.eop) begin
                    m_ptr  = (m_port + 1) % NP;
                    m_cnt  = m_cnt + 1;
                    m_busy = 0;
                end
            end
        end else begin
            req = tb_avail & tb_enable;
            for (int k = 0; k < NP; k++) begin
                if (!m_busy && req[(m_ptr + k) % NP]) begin
                    m_port  = (m_ptr + k) % NP;
                    m_busy  = 1;
                    m_first = 1;
                end
            end
        end
    endtask

    task automatic reset_checks(input string tag);
        check_eq({tag, "_grant"},  o_grant, '0);
        check_eq({tag, "_busy"},   o_busy, 1'b0);
        check_eq({tag, "_count"},  o_pkt_count, '0);
        check_eq({tag, "_err"},    o_proto_err, 1'b0);
        check_eq({tag, "_ovalid"}, out_if.valid, 1'b0);
        check_eq({tag, "_ready"},  tb_ready, '0);
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) src_q[p].delete();
        tb_valid = '0; tb_avail = '0;
        m_busy = 0; m_port = 0; m_ptr = 0; m_cnt = 0; m_first = 0; m_err = 0;
    endtask

    int remaining;

    initial begin
        for (int p = 0; p < NP; p++) tb_beat[p] = '0;
        out_ready = 1'b1;
        tb_enable = '1;
        repeat (2) @(negedge clk);
        #1 reset_checks("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single 3-beat packet on port 2, then contention between 0 and 3:
        // pointer now sits at 3, so port 3 wins first.
        add_pkt(2, 3, 0);
        repeat (6) step();
        add_pkt(0, 2, 0);
        add_pkt(3, 2, 0);
        repeat (10) step();

        // All ports busy with single-beat packets, full throughput.
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) add_pkt(p, 1, 0);
        repeat (40) step();

        // Random lengths, backpressure, source bubbles, flapping enables.
        rdy_pct = 60; vld_pct = 75; en_rand = 1;
        for (int c = 0; c < 400; c++) begin
            int p;
            p = $urandom_range(NP - 1);
            if (src_q[p].size() < 8) add_pkt(p, $urandom_range(1, 6), 0);
            step();
        end

        // Stray sop on beat 3 of some packets.
        for (int p = 0; p < NP; p += 3) add_pkt(p, 5, 1);
        repeat (150) step();

        // Reset in the middle of a long packet on port 5.
        rdy_pct = 100; vld_pct = 100; en_rand = 0;
        for (int d = 0; d < 500 && (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()
                                    + src_q[4].size() + src_q[5].size() + src_q[6].size() + src_q[7].size()) > 0; d++)
            step();
        add_pkt(5, 10, 0);
        repeat (5) step();
        check_eq("pre_rst_busy", o_busy, 1'b1);
        rst_n = 1'b0;
        #1 reset_checks("mid_rst");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        add_pkt(6, 2, 0);
        add_pkt(3, 2, 0);
        add_pkt(5, 1, 0);
        repeat (12) step();

        // Final random run then drain.
        rdy_pct = 70; vld_pct = 80; en_rand = 1;
        for (int c = 0; c < 200; c++) begin
            int p;
            p = $urandom_range(NP - 1);
            if (src_q[p].size() < 6) add_pkt(p, $urandom_range(1, 4), 0);
            step();
        end
        rdy_pct = 100; vld_pct = 100; en_rand = 0;
        remaining = 1;
        for (int d = 0; d < 2000 && remaining > 0; d++) begin
            step();
            remaining = 0;
            for (int p = 0; p < NP; p++) remaining += src_q[p].size();
        end
        check_eq("drained", remaining, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
